key_event_scheduler: RTL

Turns the USB keycode word written by the NIOS II keyboard driver, plus the two raw board push-buttons (accelerate, reset-game), into one ordered event stream with a valid/ready handshake. It debounces and edge-detects the buttons, splits keycode changes into press and release events, and arbitrates all requesters into a small show-ahead FIFO. The FIFO is drained by the game-state logic. It sits between the SoC's PIO exports and the game FSM, on the SoC clock.

---
 rtl/key_event_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/key_event_scheduler.sv
// Debounced buttons and keycode changes merged into one ordered, show-ahead event FIFO.
// Define KEY_EVT_RELEASE_EN to also emit key release events (type 01).
module key_event_scheduler #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic [7:0]                    keycode,
   input  logic                          acc_button,
   input  logic                          res_button,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [1:0]                    evt_type,
   output logic [7:0]                    evt_code,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

   // Button index 0 = accelerate, 1 = reset-game.
   logic [1:0]    sync1_q, sync2_q, stable_q, stable_d, stable_dly_q;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    btn_pend_q, btn_pend_d, fall, gnt_btn;
   logic          overflow_q, overflow_d;

   logic       rel_pend_q, rel_pend_d, press_pend_q, press_pend_d;
   logic [7:0] rel_code_q, rel_code_d, press_code_q, press_code_d;
   logic [7:0] prev_code_q, prev_code_d;
   logic       gnt_rel, gnt_press;

   logic [9:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wptr_q, rptr_q, level;
   logic        empty, full, pop, can_wr, wr_en;
   logic [9:0]  wr_data;

   assign level  = wptr_q - rptr_q;
   assign empty  = (level == '0);
   assign full   = (level == (AW + 1)'(FIFO_DEPTH));
   assign pop    = ~empty & evt_ready;
   assign can_wr = ~full | pop;

   // Counter runs only while the synchronized level disagrees with stable.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) stable_d[i] = sync2_q[i];
            else cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   assign fall = stable_dly_q & ~stable_q;

   always_comb begin
      btn_pend_d = (btn_pend_q & ~gnt_btn) | fall;
      overflow_d = overflow_q | (|(fall & btn_pend_q & ~gnt_btn));
   end

   always_comb begin
      rel_pend_d   = rel_pend_q & ~gnt_rel;
      rel_code_d   = rel_code_q;
      press_pend_d = press_pend_q & ~gnt_press;
      press_code_d = press_code_q;
      prev_code_d  = prev_code_q;
      if (!rel_pend_q && !press_pend_q && (keycode != prev_code_q)) begin
         prev_code_d = keycode;
         if (keycode != 8'h00) begin
            press_pend_d = 1'b1;
            press_code_d = keycode;
         end
`ifdef KEY_EVT_RELEASE_EN
         if (prev_code_q != 8'h00) begin
            rel_pend_d = 1'b1;
            rel_code_d = prev_code_q;
         end
`else
         rel_code_d = rel_code_q;
`endif
      end
   end

   always_comb begin
      wr_en     = 1'b0;
      wr_data   = '0;
      gnt_rel   = 1'b0;
      gnt_press = 1'b0;
      gnt_btn   = 2'b00;
      if (can_wr) begin
         if (rel_pend_q) begin
            wr_en   = 1'b1;
            wr_data = {2'b01, rel_code_q};
            gnt_rel = 1'b1;
         end else if (press_pend_q) begin
            wr_en     = 1'b1;
            wr_data   = {2'b00, press_code_q};
            gnt_press = 1'b1;
         end else if (btn_pend_q[1]) begin
            wr_en      = 1'b1;
            wr_data    = {2'b11, 8'h00};
            gnt_btn[1] = 1'b1;
         end else if (btn_pend_q[0]) begin
            wr_en      = 1'b1;
            wr_data    = {2'b10, 8'h00};
            gnt_btn[0] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q      <= 2'b11;
         sync2_q      <= 2'b11;
         stable_q     <= 2'b11;
         stable_dly_q <= 2'b11;
         cnt_q[0]     <= '0;
         cnt_q[1]     <= '0;
         btn_pend_q   <= 2'b00;
         overflow_q   <= 1'b0;
         rel_pend_q   <= 1'b0;
         rel_code_q   <= 8'h00;
         press_pend_q <= 1'b0;
         press_code_q <= 8'h00;
         prev_code_q  <= 8'h00;
         wptr_q       <= '0;
         rptr_q       <= '0;
      end else begin
         sync1_q      <= {res_button, acc_button};
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q[0]     <= cnt_d[0];
         cnt_q[1]     <= cnt_d[1];
         btn_pend_q   <= btn_pend_d;
         overflow_q   <= overflow_d;
         rel_pend_q   <= rel_pend_d;
         rel_code_q   <= rel_code_d;
         press_pend_q <= press_pend_d;
         press_code_q <= press_code_d;
         prev_code_q  <= prev_code_d;
         if (wr_en) wptr_q <= wptr_q + 1'b1;
         if (pop)   rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_data;
   end

   assign evt_valid             = ~empty;
   assign {evt_type, evt_code}  = empty ? 10'h000 : mem_q[rptr_q[AW-1:0]];
   assign fifo_level            = level;
   assign overflow              = overflow_q;

endmodule
